// File: rtl/adder_feeder.sv
// rtl/adder_feeder.sv - operand FIFO driving the adder's AXI-stream input, with framing and beat/txn counters
module adder_feeder #(
    parameter int DATAW      = 128,
    parameter int AXIS_DATAW = 512,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  client_valid,
    input  logic [DATAW-1:0]      client_data,
    input  logic                  client_last,
    output logic                  client_ready,
    output logic                  axis_adder_interface_tvalid,
    output logic                  axis_adder_interface_tlast,
    output logic [AXIS_DATAW-1:0] axis_adder_interface_tdata,
    input  logic                  axis_adder_interface_tready,
    output logic                  in_transaction,
    output logic [15:0]           beat_count,
    output logic [15:0]           txn_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Each entry holds {last, data}
    logic [DATAW:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    state_t          state_q;
    logic [15:0]     beat_count_q, txn_count_q;

    logic            push;
    logic            pop;
    logic [DATAW:0]  head;
    logic            head_last;

    assign head      = mem_q[rd_ptr_q];
    assign head_last = head[DATAW];

    // Ready depends only on stored occupancy; rst gating keeps it low while reset is held
    assign client_ready = !rst && (count_q != CW'(FIFO_DEPTH));
    assign axis_adder_interface_tvalid = (count_q != '0);
    assign push = client_valid && client_ready;
    assign pop  = axis_adder_interface_tvalid && axis_adder_interface_tready;

    // Output beat: head zero-extended, gated so stale memory never shows while empty
    always_comb begin
        axis_adder_interface_tdata = '0;
        axis_adder_interface_tlast = 1'b0;
        if (axis_adder_interface_tvalid) begin
            axis_adder_interface_tdata[DATAW-1:0] = head[DATAW-1:0];
            axis_adder_interface_tlast            = head_last;
        end
    end

    // Next-state for pointers and occupancy
    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {client_last, client_data};
        end
    end

    // Framing state: BUSY between the first beat of a transaction and its tlast beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (pop) begin
            case (state_q)
                IDLE:    state_q <= head_last ? IDLE : BUSY;
                BUSY:    state_q <= head_last ? IDLE : BUSY;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_transaction = (state_q == BUSY);

    // Beat and transaction counters, free-running with natural 16-bit wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count_q <= '0;
            txn_count_q  <= '0;
        end else if (pop) begin
            beat_count_q <= beat_count_q + 16'd1;
            if (head_last) begin
                txn_count_q <= txn_count_q + 16'd1;
            end
        end
    end

    assign beat_count = beat_count_q;
    assign txn_count  = txn_count_q;

endmodule

// File: tb/tb_adder_feeder.sv
// tb/tb_adder_feeder.sv - scoreboard bench for adder_feeder
module tb_adder_feeder;

    localparam int DATAW      = 128;
    localparam int AXIS_DATAW = 512;
    localparam int FIFO_DEPTH = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  client_valid;
    logic [DATAW-1:0]      client_data;
    logic                  client_last;
    logic                  client_ready;
    logic                  tvalid;
    logic                  tlast;
    logic [AXIS_DATAW-1:0] tdata;
    logic                  tready;
    logic                  in_transaction;
    logic [15:0]           beat_count;
    logic [15:0]           txn_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected beats: {last, data}
    logic [DATAW:0] exp_q [$];

    adder_feeder #(
        .DATAW(DATAW),
        .AXIS_DATAW(AXIS_DATAW),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .client_valid(client_valid),
        .client_data(client_data),
        .client_last(client_last),
        .client_ready(client_ready),
        .axis_adder_interface_tvalid(tvalid),
        .axis_adder_interface_tlast(tlast),
        .axis_adder_interface_tdata(tdata),
        .axis_adder_interface_tready(tready),
        .in_transaction(in_transaction),
        .beat_count(beat_count),
        .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [AXIS_DATAW-1:0] act,
                         input logic [AXIS_DATAW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand for one cycle; caller guarantees it is accepted
    task automatic push_one(input logic [DATAW-1:0] d, input logic l);
        client_valid = 1'b1;
        client_data  = d;
        client_last  = l;
        exp_q.push_back({l, d});
        tick();
        client_valid = 1'b0;
        client_last  = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every handshake and checks AXI hold stability
    logic                  prev_stall = 1'b0;
    logic [AXIS_DATAW-1:0] prev_tdata;
    logic                  prev_tlast;
    always @(negedge clk) begin
        logic [DATAW:0] e;
        logic [AXIS_DATAW-1:0] ext;
        if (prev_stall && !rst) begin
            check("hold_tvalid", AXIS_DATAW'(tvalid), AXIS_DATAW'(1));
            check("hold_tdata", tdata, prev_tdata);
            check("hold_tlast", AXIS_DATAW'(tlast), AXIS_DATAW'(prev_tlast));
        end
        prev_stall = tvalid && !tready && !rst;
        prev_tdata = tdata;
        prev_tlast = tlast;
        if (tvalid && tready && !rst) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", tdata, '0);
                n_checks++;
                n_fail++;
                $display("FAIL beat_without_expectation: got tdata %0h expected no beat", tdata);
            end else begin
                e = exp_q.pop_front();
                ext = '0;
                ext[DATAW-1:0] = e[DATAW-1:0];
                check("beat_tdata", tdata, ext);
                check("beat_tlast", AXIS_DATAW'(tlast), AXIS_DATAW'(e[DATAW]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        client_valid = 1'b0;
        client_data  = '0;
        client_last  = 1'b0;
        tready       = 1'b0;

        // Test 1: reset held 3 cycles, outputs zero throughout
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_client_ready", AXIS_DATAW'(client_ready), '0);
            check("rst_tvalid", AXIS_DATAW'(tvalid), '0);
            check("rst_tlast", AXIS_DATAW'(tlast), '0);
            check("rst_tdata", tdata, '0);
            check("rst_in_txn", AXIS_DATAW'(in_transaction), '0);
            check("rst_beats", AXIS_DATAW'(beat_count), '0);
            check("rst_txns", AXIS_DATAW'(txn_count), '0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("release_ready", AXIS_DATAW'(client_ready), AXIS_DATAW'(1));
        check("release_tvalid", AXIS_DATAW'(tvalid), '0);
        tick();

        // Test 2: three-beat transaction streamed with tready high
        tready = 1'b1;
        push_one(128'd5, 1'b0);
        push_one(128'd7, 1'b0);
        check("t2_in_txn_busy", AXIS_DATAW'(in_transaction), AXIS_DATAW'(1));
        push_one(128'd9, 1'b1);
        tick();
        tick();
        check("t2_in_txn_idle", AXIS_DATAW'(in_transaction), '0);
        check("t2_beats", AXIS_DATAW'(beat_count), AXIS_DATAW'(3));
        check("t2_txns", AXIS_DATAW'(txn_count), AXIS_DATAW'(1));

        // Test 3: fill the FIFO with tready low
        tready = 1'b0;
        client_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            client_data = 128'(i);
            client_last = (i == 16);
            exp_q.push_back({client_last, client_data});
            tick();
        end
        client_valid = 1'b0;
        client_last  = 1'b0;
        check("t3_full_ready", AXIS_DATAW'(client_ready), '0);
        check("t3_tdata_head", tdata, AXIS_DATAW'(1));
        tick();
        tick();
        check("t3_tdata_hold", tdata, AXIS_DATAW'(1));

        // Test 4: push and pop in the same cycle at full; push is refused
        tready       = 1'b1;
        client_valid = 1'b1;
        client_data  = 128'd99;
        check("t4_ready_at_full", AXIS_DATAW'(client_ready), '0);
        tick();
        client_valid = 1'b0;
        tready       = 1'b0;
        check("t4_ready_at_15", AXIS_DATAW'(client_ready), AXIS_DATAW'(1));
        check("t4_next_head", tdata, AXIS_DATAW'(2));

        // Drain the remaining 15 beats
        tready = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("t3_drained_tvalid", AXIS_DATAW'(tvalid), '0);
        check("t3_beats", AXIS_DATAW'(beat_count), AXIS_DATAW'(19));
        check("t3_txns", AXIS_DATAW'(txn_count), AXIS_DATAW'(2));
        check("t3_in_txn", AXIS_DATAW'(in_transaction), '0);

        // Test 5: single-beat transaction
        push_one(128'hFFFF_FFFF, 1'b1);
        check("t5_tvalid", AXIS_DATAW'(tvalid), AXIS_DATAW'(1));
        check("t5_tdata", tdata, AXIS_DATAW'(128'hFFFF_FFFF));
        check("t5_upper_zero", AXIS_DATAW'(tdata[AXIS_DATAW-1:DATAW]), '0);
        check("t5_in_txn_before", AXIS_DATAW'(in_transaction), '0);
        tick();
        check("t5_in_txn_after", AXIS_DATAW'(in_transaction), '0);
        check("t5_txns", AXIS_DATAW'(txn_count), AXIS_DATAW'(3));
        check("t5_beats", AXIS_DATAW'(beat_count), AXIS_DATAW'(20));

        // Test 6: reset mid-transaction with two beats sent and two queued
        push_one(128'hA, 1'b0);
        push_one(128'hB, 1'b0);
        push_one(128'hC, 1'b0);
        tready = 1'b0;
        push_one(128'hD, 1'b1);
        check("t6_busy", AXIS_DATAW'(in_transaction), AXIS_DATAW'(1));
        check("t6_beats_pre", AXIS_DATAW'(beat_count), AXIS_DATAW'(22));
        check("t6_head_c", tdata, AXIS_DATAW'(128'hC));
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        #1;
        check("t6_tvalid", AXIS_DATAW'(tvalid), '0);
        check("t6_beats", AXIS_DATAW'(beat_count), '0);
        check("t6_txns", AXIS_DATAW'(txn_count), '0);
        check("t6_in_txn", AXIS_DATAW'(in_transaction), '0);
        check("t6_tdata", tdata, '0);
        check("t6_ready", AXIS_DATAW'(client_ready), AXIS_DATAW'(1));
        tready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t6_no_stale", AXIS_DATAW'(tvalid), '0);
        check("t6_beats_after", AXIS_DATAW'(beat_count), '0);

        check("scoreboard_empty", AXIS_DATAW'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
